key_event_uart_tx: RTL and testbench
====================================

Name: key_event_uart_tx

Overview:
Consumes the keyboard event stream (keyEventReady strobe plus the 8-bit keyEvent code) produced by the keyboard reader, and buffers events in a small FIFO. Transmits each event code to the host MCU as one asynchronous 8N1 UART frame on txd. It is the host-facing end of the key event interface and runs on the main 48 MHz clk.

Parameters:
CLK_DIV, 417, clk cycles per UART bit (417 gives ~115200 baud at 48 MHz); legal range 2..65535
FIFO_DEPTH, 16, event FIFO entries; power of two
FIFO_AW, 4, FIFO address width, log2(FIFO_DEPTH)

Ports:
clk  input  1  system clock; all logic on posedge clk
rst  input  1  reset, synchronous, active-high
keyEventReady  input  1  event flag, already synchronised to clk; may be high for 1 or more cycles, and one event is taken per rising edge
keyEvent  input  8  event code, valid in the cycle keyEventReady is first seen high; [7:6]=01 press, 10 release, 11 encoder/patient button
clrOverflow  input  1  one-cycle pulse that clears overflow
txd  output  1  UART serial out, idle high
busy  output  1  high while the FIFO is non-empty or a frame is in progress
fifoLevel  output  FIFO_AW+1  current FIFO occupancy, 0..FIFO_DEPTH
overflow  output  1  sticky flag: an event was dropped because the FIFO was full

Behaviour:
- Reset (synchronous, active-high): txd=1, busy=0, fifoLevel=0, overflow=0; FSM to IDLE; bit timer=0; rdyD=1 so a keyEventReady held high through reset does not create an event.
- Edge detect: rdyD is keyEventReady delayed one cycle. strobe = keyEventReady & ~rdyD. keyEvent is captured in the strobe cycle.
- Filtering: code 8'h00 (no source) is discarded silently. It is not pushed and overflow is unaffected.
- Push happens the cycle after the strobe if the FIFO is not full.
  - If the FIFO is full: the event is dropped and overflow=1.
  - Simultaneous push and pop while full: the pop frees a slot and the push is accepted; level is unchanged and overflow is not set.
- FIFO: circular buffer with FIFO_AW-bit pointers that wrap naturally. fifoLevel increments on push and decrements on pop, net 0 when both occur.
- overflow: set on a drop; cleared by clrOverflow. Set wins when both occur in the same cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If the FIFO is not empty, pop into an 8-bit shift register, load the bit timer with CLK_DIV-1 and go to START.
  - START: txd=0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each; a 3-bit counter selects the bit.
  - STOP: txd=1 for CLK_DIV cycles. At the end, if the FIFO is not empty, pop and go directly to START, with no idle gap between frames. Otherwise go to IDLE.
- Bit timer: counts down from CLK_DIV-1 to 0. At 0 it advances to the next bit and reloads.
- Frame length: exactly 10*CLK_DIV cycles.
- Latency: with the FIFO empty and the FSM in IDLE, txd first reads 0 three rising edges after the edge that sampled the strobe. The three edges are push, pop/load, then txd registered low.
- txd is driven from a register, so it is glitch-free.
- busy = (state != IDLE) | (fifoLevel != 0).
- Reset mid-frame: txd returns high on the next edge and the frame is truncated; the FIFO is emptied.

Optional Feature:
Macro KEY_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLK_DIV cycles, making the frame 8E1 and 11*CLK_DIV cycles long.
- Not defined: 8N1 as described above, and no parity logic is built.

Test Plan:
- Single event (CLK_DIV=4): pulse keyEventReady one cycle with keyEvent=8'h45 -> txd low 3 edges later, then the pattern 0,1,0,1,0,0,0,1,0,1 (4 cycles each); busy drops after 40 cycles; fifoLevel peaks at 1.
- Held flag and zero code: keyEventReady held high 20 cycles with 8'h83 -> exactly one frame is sent. A strobe with 8'h00 -> no frame, fifoLevel stays 0, overflow stays 0.
- Back-to-back (CLK_DIV=4): events 8'h41, 8'h42, 8'hC3 strobed 2 cycles apart -> three contiguous frames totalling 120 cycles, with no idle bit between the stop and start bits.
- Overflow (CLK_DIV=4, DEPTH=16):
  - 18 events (8'h41..8'h52) strobed every 2 cycles -> first 17 are transmitted in order, 8'h52 is dropped, overflow=1.
  - clrOverflow pulse -> overflow=0.
  - Set and clear in the same cycle -> overflow stays 1.
- Reset mid-frame: assert rst during bit 3 of a frame with 2 events queued -> txd=1, fifoLevel=0, busy=0 next edge; no further frames.
- With KEY_TX_PARITY_EN defined: 8'h45 (3 ones) -> parity bit 1 before the stop bit; 8'h41 (2 ones) -> parity bit 0; frame length 44 cycles at CLK_DIV=4.

Source files
------------

// File: rtl/key_event_uart_tx_if.sv
// Key event interface between the keyboard side and the UART transmitter.
// master: event source / monitor; slave: key_event_uart_tx.
interface key_event_uart_tx_if #(
    parameter int FIFO_AW = 4
);
    logic             keyEventReady;
    logic [7:0]       keyEvent;
    logic             clrOverflow;
    logic             txd;
    logic             busy;
    logic [FIFO_AW:0] fifoLevel;
    logic             overflow;

    modport master (
        output keyEventReady, keyEvent, clrOverflow,
        input  txd, busy, fifoLevel, overflow
    );

    modport slave (
        input  keyEventReady, keyEvent, clrOverflow,
        output txd, busy, fifoLevel, overflow
    );
endinterface

// File: rtl/key_event_uart_tx.sv
// Key event FIFO + UART transmitter: buffers keyboard event codes and
// sends each as one 8N1 frame (8E1 when KEY_TX_PARITY_EN is defined).
// Ports: clk, rst (sync, active-high), bus (key_event_uart_tx_if.slave):
//   keyEventReady/keyEvent/clrOverflow in; txd/busy/fifoLevel/overflow out.
module key_event_uart_tx #(
    parameter int CLK_DIV    = 417,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    key_event_uart_tx_if.slave   bus
);

    localparam logic [15:0]      DIV_M1  = 16'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0] LV_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

`ifdef KEY_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;
`endif

    state_t             r_state;
    logic               r_rdyD;
    logic               r_evValid;
    logic [7:0]         r_evCode;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_level;
    logic               r_ovf;
    logic [15:0]        r_timer;
    logic [2:0]         r_bitCnt;
    logic [7:0]         r_shift;
    logic               r_txd;
`ifdef KEY_TX_PARITY_EN
    logic               r_par;
`endif

    logic       w_strobe;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    logic [7:0] w_rdData;

    assign w_strobe = bus.keyEventReady & ~r_rdyD;
    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == LV_FULL);
    assign w_rdData = r_mem[r_rptr];

    // Pop from IDLE, or at the very end of STOP for back-to-back frames.
    assign w_pop = !w_empty &&
                   ((r_state == S_IDLE) ||
                    ((r_state == S_STOP) && (r_timer == '0)));

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push = r_evValid && (!w_full || w_pop);
    assign w_drop = r_evValid && w_full && !w_pop;

    // Edge detect and capture; rdyD resets high so a held flag is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdyD    <= 1'b1;
            r_evValid <= 1'b0;
            r_evCode  <= '0;
        end else begin
            r_rdyD    <= bus.keyEventReady;
            r_evValid <= w_strobe && (bus.keyEvent != 8'h00);
            r_evCode  <= bus.keyEvent;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wptr] <= r_evCode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.clrOverflow) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // txd is registered from the state, so it trails the state by one
    // cycle; every bit still lasts exactly CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_bitCnt <= '0;
            r_shift  <= '0;
            r_txd    <= 1'b1;
`ifdef KEY_TX_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_START:  r_txd <= 1'b0;
                S_DATA:   r_txd <= r_shift[0];
`ifdef KEY_TX_PARITY_EN
                S_PARITY: r_txd <= r_par;
`endif
                default:  r_txd <= 1'b1;
            endcase

            unique case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                end
                S_START: begin
                    if (r_timer == '0) begin
                        r_timer  <= DIV_M1;
                        r_bitCnt <= '0;
                        r_state  <= S_DATA;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_timer == '0) begin
                        r_timer  <= DIV_M1;
                        r_shift  <= {1'b0, r_shift[7:1]};
                        r_bitCnt <= r_bitCnt + 1'b1;
                        if (r_bitCnt == 3'd7) begin
`ifdef KEY_TX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
`ifdef KEY_TX_PARITY_EN
                S_PARITY: begin
                    if (r_timer == '0) begin
                        r_timer <= DIV_M1;
                        r_state <= S_STOP;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (r_timer == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Frame load overrides the per-state updates above.
            if (w_pop) begin
                r_shift <= w_rdData;
                r_timer <= DIV_M1;
                r_state <= S_START;
`ifdef KEY_TX_PARITY_EN
                r_par   <= ^w_rdData;
`endif
            end
        end
    end

    assign bus.txd       = r_txd;
    assign bus.busy      = (r_state != S_IDLE) || !w_empty;
    assign bus.fifoLevel = r_level;
    assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_key_event_uart_tx.sv
// Self-checking bench for key_event_uart_tx at CLK_DIV=4, depth 16.
// A UART receiver decodes txd and is checked against an event queue.
module tb_key_event_uart_tx;

    localparam int DIV = 4;
`ifdef KEY_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;

    logic clk;
    logic rst;
    longint cyc;
    int checks;
    int errors;
    int lowCnt;

    key_event_uart_tx_if #(.FIFO_AW(4)) bus ();

    key_event_uart_tx #(
        .CLK_DIV(DIV), .FIFO_DEPTH(16), .FIFO_AW(4)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (!rst && bus.txd == 1'b0) lowCnt++;

    typedef struct {
        logic [7:0] d;
        bit         ok;
        longint     t0;
    } frame_t;

    frame_t     rxq[$];
    logic [7:0] expq[$];

    // Receiver: samples each bit in its middle (negedge offset 2 of DIV).
    initial begin
        frame_t f;
        logic   st;
        logic   sp;
        forever begin
            @(negedge clk);
            if (!rst && bus.txd == 1'b0) begin
                f.t0 = cyc;
                repeat (2) @(negedge clk);
                st = bus.txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    f.d[i] = bus.txd;
                end
                f.ok = (st == 1'b0);
`ifdef KEY_TX_PARITY_EN
                repeat (DIV) @(negedge clk);
                if (bus.txd != ^f.d) f.ok = 1'b0;
`endif
                repeat (DIV) @(negedge clk);
                sp = bus.txd;
                if (sp != 1'b1) f.ok = 1'b0;
                rxq.push_back(f);
                @(negedge clk);
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.busy) begin
            errors++;
            $display("FAIL idle_timeout: busy=1 after %0d cycles", budget);
        end
        repeat (DIV * 3) @(negedge clk);
    endtask

    task automatic chk_frames(input string nm);
        int n;
        chk({nm, "_count"}, rxq.size(), expq.size());
        n = (rxq.size() < expq.size()) ? rxq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk({nm, "_data"}, rxq[i].d, expq[i]);
            chk({nm, "_framing"}, rxq[i].ok, 1);
        end
        rxq.delete();
        expq.delete();
    endtask

    // Strobe one event; keyEvent is scrambled after the first cycle
    // since only the strobe-cycle value is meaningful.
    task automatic send(input logic [7:0] code, input int hold);
        @(negedge clk);
        bus.keyEventReady = 1'b1;
        bus.keyEvent      = code;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.keyEvent = ~code;
        end
        bus.keyEventReady = 1'b0;
    endtask

    typedef struct {
        logic [7:0] code;
        int         hold;
        int         nexp;
    } vec_t;

    vec_t tv[6];

    initial begin
        logic [7:0] c;
        int         h;
        checks = 0;
        errors = 0;
        lowCnt = 0;

        tv[0] = '{8'h45, 1, 1};
        tv[1] = '{8'h83, 20, 1};
        tv[2] = '{8'h00, 1, 0};
        tv[3] = '{8'h41, 3, 1};
        tv[4] = '{8'hC3, 2, 1};
        tv[5] = '{8'hFF, 1, 1};

        // Flag held high through reset must not create an event.
        rst               = 1'b1;
        bus.keyEventReady = 1'b1;
        bus.keyEvent      = 8'h55;
        bus.clrOverflow   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_txd", bus.txd, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_level", bus.fifoLevel, 0);
        chk("rst_ovf", bus.overflow, 0);
        repeat (10) @(negedge clk);
        chk("held_rst_level", bus.fifoLevel, 0);
        chk("held_rst_busy", bus.busy, 0);
        bus.keyEventReady = 1'b0;
        repeat (4) @(negedge clk);

        // Latency and level/busy timing for a single event.
        bus.keyEventReady = 1'b1;
        bus.keyEvent      = 8'h45;
        @(posedge clk);
        #1 bus.keyEventReady = 1'b0;
        chk("lat_e0_txd", bus.txd, 1);
        @(posedge clk); #1;
        chk("lat_e1_level", bus.fifoLevel, 1);
        chk("lat_e1_busy", bus.busy, 1);
        @(posedge clk); #1;
        chk("lat_e2_txd", bus.txd, 1);
        chk("lat_e2_level", bus.fifoLevel, 0);
        @(posedge clk); #1;
        chk("lat_e3_txd", bus.txd, 0);
        repeat (FRAME - 2) @(posedge clk);
        #1 chk("busy_last", bus.busy, 1);
        @(posedge clk);
        #1 chk("busy_drop", bus.busy, 0);
        repeat (DIV * 3) @(negedge clk);
        expq.push_back(8'h45);
        chk_frames("single");

        // Vector table.
        for (int i = 0; i < 6; i++) begin
            send(tv[i].code, tv[i].hold);
            if (tv[i].nexp != 0) expq.push_back(tv[i].code);
            repeat (3) @(negedge clk);
            wait_idle(200);
            chk_frames($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_level", i), bus.fifoLevel, 0);
            chk($sformatf("vec%0d_ovf", i), bus.overflow, 0);
        end

        // Back-to-back frames must be contiguous.
        send(8'h41, 1);
        send(8'h42, 1);
        send(8'hC3, 1);
        repeat (3) @(negedge clk);
        wait_idle(400);
        chk("b2b_count", rxq.size(), 3);
        if (rxq.size() == 3) begin
            chk("b2b_gap1", rxq[1].t0 - rxq[0].t0, FRAME);
            chk("b2b_gap2", rxq[2].t0 - rxq[1].t0, FRAME);
        end
        expq = '{8'h41, 8'h42, 8'hC3};
        chk_frames("b2b");

        // Overflow: 18 events, the last one is dropped.
        for (int i = 0; i < 18; i++) begin
            c = 8'h41 + 8'(i);
            send(c, 1);
            if (i < 17) expq.push_back(c);
        end
        repeat (3) @(negedge clk);
        chk("ovf_set", bus.overflow, 1);
        wait_idle(2000);
        chk_frames("ovf");
        chk("ovf_sticky", bus.overflow, 1);
        @(negedge clk) bus.clrOverflow = 1'b1;
        @(negedge clk) bus.clrOverflow = 1'b0;
        chk("ovf_clear", bus.overflow, 0);

        // Drop and clear in the same cycle: set wins.
        for (int i = 0; i < 17; i++) send(8'h60 + 8'(i), 1);
        @(negedge clk);
        bus.keyEventReady = 1'b1;
        bus.keyEvent      = 8'h7F;
        @(negedge clk);
        bus.keyEventReady = 1'b0;
        bus.clrOverflow   = 1'b1;
        @(negedge clk);
        bus.clrOverflow   = 1'b0;
        chk("ovf_set_wins", bus.overflow, 1);
        wait_idle(2000);
        chk("ovf2_count", rxq.size(), 17);
        rxq.delete();
        @(negedge clk) bus.clrOverflow = 1'b1;
        @(negedge clk) bus.clrOverflow = 1'b0;

        // Randomized bursts against the queue model (no overflow).
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 10; i++) begin
                c = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                h = $urandom_range(1, 4);
                send(c, h);
                if (c != 8'h00) expq.push_back(c);
                repeat ($urandom_range(1, 30)) @(negedge clk);
            end
            repeat (3) @(negedge clk);
            wait_idle(3000);
            chk_frames($sformatf("rnd%0d", b));
            chk($sformatf("rnd%0d_ovf", b), bus.overflow, 0);
        end

        // Reset during data bit 3 with two events queued.
        send(8'h45, 1);
        send(8'h46, 1);
        send(8'h47, 1);
        repeat (16) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_txd", bus.txd, 1);
        chk("mid_rst_level", bus.fifoLevel, 0);
        chk("mid_rst_busy", bus.busy, 0);
        @(negedge clk) rst = 1'b0;
        lowCnt = 0;
        repeat (200) @(negedge clk);
        chk("mid_rst_no_frames", lowCnt, 0);
        chk("mid_rst_idle", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
